// File: rtl/servant_spi_arbiter.sv
// Two-master arbiter that multiplexes the SERV instruction and data buses onto
// a single SPI memory master, with per-grant timeout protection.
module servant_spi_arbiter #(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-3:0] i_ibus_adr,
  input  logic                     i_ibus_cyc,
  output logic [31:0]              o_ibus_rdt,
  output logic                     o_ibus_ack,
  input  logic [ADDRESS_WIDTH-3:0] i_dbus_adr,
  input  logic [31:0]              i_dbus_dat,
  input  logic [3:0]               i_dbus_sel,
  input  logic                     i_dbus_we,
  input  logic                     i_dbus_cyc,
  output logic [31:0]              o_dbus_rdt,
  output logic                     o_dbus_ack,
  output logic [ADDRESS_WIDTH-3:0] o_spi_adr,
  output logic [31:0]              o_spi_dat,
  output logic [3:0]               o_spi_sel,
  output logic                     o_spi_we,
  output logic                     o_spi_cyc,
  input  logic [31:0]              i_spi_rdt,
  input  logic                     i_spi_ack,
  output logic                     o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          last_dbus_r;
  logic [CW-1:0] count_r;
  logic          start_i_s;
  logic          start_d_s;
  logic          done_s;
  logic          timeout_s;
  logic          in_grant_s;
  logic          ack_i_s;
  logic          ack_d_s;
  logic [31:0]   rdt_s;

  assign in_grant_s = (state_r == GRANT_I) || (state_r == GRANT_D);
  assign ack_i_s    = done_s && (state_r == GRANT_I) && i_ibus_cyc;
  assign ack_d_s    = done_s && (state_r == GRANT_D) && i_dbus_cyc;
  assign rdt_s      = timeout_s ? 32'hFFFF_FFFF : i_spi_rdt;

  // Arbitration and termination decisions; a tie goes to the bus not served last.
  always_comb begin
    state_s   = state_r;
    start_i_s = 1'b0;
    start_d_s = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_ibus_cyc && i_dbus_cyc) begin
          if (last_dbus_r) begin
            start_i_s = 1'b1;
            state_s   = GRANT_I;
          end else begin
            start_d_s = 1'b1;
            state_s   = GRANT_D;
          end
        end else if (i_ibus_cyc) begin
          start_i_s = 1'b1;
          state_s   = GRANT_I;
        end else if (i_dbus_cyc) begin
          start_d_s = 1'b1;
          state_s   = GRANT_D;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (i_spi_ack) begin
          done_s  = 1'b1;
          state_s = DONE;
        end else if (count_r == COUNT_LAST) begin
          done_s    = 1'b1;
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, fairness history, grant timer and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      last_dbus_r <= 1'b1;
      count_r     <= {CW{1'b0}};
      o_spi_cyc   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state_r   <= state_s;
      o_spi_cyc <= (state_s == GRANT_I) || (state_s == GRANT_D);
      o_timeout <= o_timeout | timeout_s;
      if (start_i_s) begin
        last_dbus_r <= 1'b0;
      end else if (start_d_s) begin
        last_dbus_r <= 1'b1;
      end else begin
        last_dbus_r <= last_dbus_r;
      end
      if (start_i_s || start_d_s) begin
        count_r <= {CW{1'b0}};
      end else if (in_grant_s && (count_r != COUNT_LAST)) begin
        count_r <= count_r + COUNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Request fields are frozen at grant time so upstream changes cannot leak in.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_spi_adr <= {(ADDRESS_WIDTH-2){1'b0}};
      o_spi_dat <= 32'h0000_0000;
      o_spi_sel <= 4'h0;
      o_spi_we  <= 1'b0;
    end else if (start_i_s) begin
      o_spi_adr <= i_ibus_adr;
      o_spi_dat <= 32'h0000_0000;
      o_spi_sel <= 4'hF;
      o_spi_we  <= 1'b0;
    end else if (start_d_s) begin
      o_spi_adr <= i_dbus_adr;
      o_spi_dat <= i_dbus_dat;
      o_spi_sel <= i_dbus_sel;
      o_spi_we  <= i_dbus_we;
    end else begin
      o_spi_adr <= o_spi_adr;
      o_spi_dat <= o_spi_dat;
      o_spi_sel <= o_spi_sel;
      o_spi_we  <= o_spi_we;
    end
  end

  // Completion responses; a bus that abandoned its request gets neither ack nor data.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;
      o_ibus_rdt <= 32'h0000_0000;
      o_dbus_rdt <= 32'h0000_0000;
    end else begin
      o_ibus_ack <= ack_i_s;
      o_dbus_ack <= ack_d_s;
      o_ibus_rdt <= ack_i_s ? rdt_s : o_ibus_rdt;
      o_dbus_rdt <= ack_d_s ? rdt_s : o_dbus_rdt;
    end
  end

endmodule

// File: doc/servant_spi_arbiter.md
SERVANT_SPI_ARBITER -- requirements
Module: servant_spi_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 24, byte-address width of the SPI memory space.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, clocks allowed per granted transaction before forced termination.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_ibus_adr  input  ADDRESS_WIDTH-2  instruction word address.
REQ-006 i_ibus_cyc  input  1  instruction read request (ibus is read-only, full-word).
REQ-007 o_ibus_rdt  output  32  instruction read data.
REQ-008 o_ibus_ack  output  1  instruction transfer complete, one-cycle pulse.
REQ-009 i_dbus_adr  input  ADDRESS_WIDTH-2  data word address.
REQ-010 i_dbus_dat  input  32  data write data.
REQ-011 i_dbus_sel  input  4  data byte lanes; 4'h0 = status/config access.
REQ-012 i_dbus_we  input  1  data write enable.
REQ-013 i_dbus_cyc  input  1  data request.
REQ-014 o_dbus_rdt  output  32  data read data.
REQ-015 o_dbus_ack  output  1  data transfer complete, one-cycle pulse.
REQ-016 o_spi_adr / o_spi_dat / o_spi_sel / o_spi_we  output  ADDRESS_WIDTH-2 / 32 / 4 / 1  request to SPI master interface.
REQ-017 o_spi_cyc  output  1  request valid to SPI master interface.
REQ-018 i_spi_rdt  input  32  read data from SPI master interface.
REQ-019 i_spi_ack  input  1  completion from SPI master interface.
REQ-020 o_timeout  output  1  sticky flag, set when any transaction times out.

Function
REQ-021 States: IDLE, GRANT_I, GRANT_D, DONE; encoding free.
REQ-022 IDLE: i_dbus_cyc only -> GRANT_D; i_ibus_cyc only -> GRANT_I; both -> bus not granted last time wins (last_grant register, reset value = dbus, so ibus wins first tie); neither -> stay.
REQ-023 On the IDLE->GRANT edge, winner's adr/dat/sel/we are registered into o_spi_*; ibus grant drives o_spi_sel=4'hF, o_spi_we=0, o_spi_dat=0.
REQ-024 o_spi_cyc is 1 exactly in GRANT_I/GRANT_D; request in IDLE at edge N gives o_spi_cyc=1 after edge N+1 (one-cycle latency).
REQ-025 o_spi_* fields hold constant throughout a grant regardless of upstream input changes.
REQ-026 i_spi_ack=1 in GRANT_x: capture i_spi_rdt into o_x_rdt, pulse o_x_ack for one cycle, drop o_spi_cyc, go DONE.
REQ-027 DONE lasts exactly one cycle, o_spi_cyc=0, no new grant, then IDLE; guarantees SPI master sees cyc low before next request.
REQ-028 o_x_rdt holds last captured value until next completion for that bus; write completions also update rdt with i_spi_rdt.
REQ-029 i_spi_ack outside GRANT states is ignored.
REQ-030 Upstream cyc dropped mid-grant: grant continues until i_spi_ack or timeout; ack to that bus suppressed, rdt not updated.
REQ-031 Timeout counter cleared on entry to GRANT, increments each GRANT cycle; reaching TIMEOUT_CYCLES-1 without i_spi_ack: o_x_rdt=32'hFFFFFFFF, o_x_ack pulse, o_timeout=1, -> DONE.
REQ-032 i_spi_ack on the same cycle as timeout: normal completion wins, o_timeout unchanged.
REQ-033 Counter width ceil(log2(TIMEOUT_CYCLES)); no wrap possible.
REQ-034 Ack pulses never both 1; at most one ack per grant.

Reset
REQ-035 reset=1 at an edge: state=IDLE, o_spi_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_ibus_rdt=0, o_dbus_rdt=0, o_spi_adr/dat/sel/we=0, o_timeout=0, last_grant=dbus, counter=0.
REQ-036 Reset mid-grant aborts immediately; no ack issued afterward for the aborted transaction.

Verification
REQ-037 ibus read adr=0x000100, SPI ack after 300 cycles with rdt=0x00000297 -> o_spi_sel=F, o_ibus_ack one pulse, o_ibus_rdt=0x00000297.
REQ-038 ibus and dbus cyc asserted same cycle after reset -> ibus granted first, dbus next after DONE; repeat -> alternation I,D,I,D.
REQ-039 dbus write adr=0x000040 dat=0xDEADBEEF sel=4'b0011, inputs changed during grant -> o_spi_* stay at original values until ack.
REQ-040 TIMEOUT_CYCLES=16, no SPI ack -> o_dbus_ack at grant cycle 15, o_dbus_rdt=0xFFFFFFFF, o_timeout=1 sticky until reset.
REQ-041 reset asserted mid-grant -> o_spi_cyc=0 next cycle, no ack; subsequent request processed normally.
REQ-042 i_spi_ack while IDLE or DONE -> no ack to either bus, state unchanged.
